// File: rtl/jump_pkg.sv
// Shared types, widths and helpers for the jump sequencer.
// Exports jump_state_t, jump_dir_t, VY_W, CHARGE_W, dir_of, vy_of, sat_inc.
package jump_pkg;

  localparam int VY_W     = 12;
  localparam int CHARGE_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHARGE,
    ST_LAUNCH,
    ST_AIR,
    ST_HOLD
  } jump_state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } jump_dir_t;

  // Exactly one key pressed picks a side; both or neither is vertical.
  function automatic jump_dir_t dir_of(
    input logic l,
    input logic r
  );
    unique case (1'b1)
      (l & ~r): return DIR_LEFT;
      (r & ~l): return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

  function automatic logic [VY_W-1:0] vy_of(
    input logic [CHARGE_W-1:0] c,
    input logic [VY_W-1:0]     s
  );
    return VY_W'(c) * s;
  endfunction

  function automatic logic [CHARGE_W-1:0] sat_inc(
    input logic [CHARGE_W-1:0] c,
    input logic [CHARGE_W-1:0] m
  );
    return (c >= m) ? m : c + 1'b1;
  endfunction

endpackage

// File: rtl/jump_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clk cycles.
// Ports: clk, rst (async, active-high), tick (high while count is TICK_DIV-1).
module jump_tick_gen #(
  parameter int TICK_DIV = 666_667
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jump_ctl.sv
// Jump sequencer: walk while grounded, charge while space held, one-shot
// launch over valid/ready on release, then lock out input until landing.
// Ports: clk, rst, key_space/left/right, landed, launch_ready in;
// launch_valid/vy/dir, walk_left/right, charging, charge_level out.
// Option: JUMP_CTL_AUTO_RELEASE_EN launches as soon as charge saturates.
module jump_ctl
  import jump_pkg::*;
#(
  parameter int TICK_DIV   = 666_667,
  parameter int CHARGE_MAX = 32,
  parameter int VEL_STEP   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_space,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                landed,
  input  logic                launch_ready,
  output logic                launch_valid,
  output logic [VY_W-1:0]     launch_vy,
  output logic [1:0]          launch_dir,
  output logic                walk_left,
  output logic                walk_right,
  output logic                charging,
  output logic [CHARGE_W-1:0] charge_level
);

`ifdef JUMP_CTL_AUTO_RELEASE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam logic [CHARGE_W-1:0] CMAX = CHARGE_W'(CHARGE_MAX);
  localparam logic [VY_W-1:0]     STEP = VY_W'(VEL_STEP);

  logic                tick;
  jump_state_t         state;
  jump_dir_t           dir_q;
  logic                space_q;
  logic [CHARGE_W-1:0] charge;
  logic [CHARGE_W-1:0] charge_nx;
  logic                rise;
  logic                wl_nx;
  logic                wr_nx;
  logic                fire;

  jump_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Tick increment is applied before a same-cycle release is latched.
  assign charge_nx = tick ? sat_inc(charge, CMAX) : charge;
  assign rise      = key_space & ~space_q;
  assign wl_nx     = key_left & ~key_right & landed;
  assign wr_nx     = key_right & ~key_left & landed;
  assign fire      = ~key_space | (AUTO & (charge == CMAX));

  assign charge_level = charge;
  assign launch_dir   = dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      space_q      <= 1'b0;
      charge       <= '0;
      charging     <= 1'b0;
      launch_valid <= 1'b0;
      launch_vy    <= '0;
      dir_q        <= DIR_NONE;
      walk_left    <= 1'b0;
      walk_right   <= 1'b0;
    end else begin
      space_q    <= key_space;
      walk_left  <= 1'b0;
      walk_right <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!landed) begin
            state <= ST_AIR;
          end else if (rise) begin
            state    <= ST_CHARGE;
            charge   <= CHARGE_W'(1);
            charging <= 1'b1;
          end else begin
            walk_left  <= wl_nx;
            walk_right <= wr_nx;
          end
        end
        ST_CHARGE: begin
          // Losing ground aborts the jump outright.
          if (!landed) begin
            state    <= ST_AIR;
            charge   <= '0;
            charging <= 1'b0;
          end else if (fire) begin
            state        <= ST_LAUNCH;
            charging     <= 1'b0;
            charge       <= charge_nx;
            launch_valid <= 1'b1;
            launch_vy    <= vy_of(charge_nx, STEP);
            dir_q        <= dir_of(key_left, key_right);
          end else begin
            charge <= charge_nx;
          end
        end
        ST_LAUNCH: begin
          if (launch_ready) begin
            state        <= ST_AIR;
            launch_valid <= 1'b0;
            launch_vy    <= '0;
            dir_q        <= DIR_NONE;
            charge       <= '0;
          end
        end
        ST_AIR: begin
          if (landed) begin
            if (key_space) begin
              state <= ST_HOLD;
            end else begin
              state      <= ST_IDLE;
              walk_left  <= wl_nx;
              walk_right <= wr_nx;
            end
          end
        end
        ST_HOLD: begin
          if (!key_space) begin
            state      <= ST_IDLE;
            walk_left  <= wl_nx;
            walk_right <= wr_nx;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_ctl.sv
// Directed bench for jump_ctl with TICK_DIV=4, CHARGE_MAX=32, VEL_STEP=2.
// Honours JUMP_CTL_AUTO_RELEASE_EN for the saturation scenario.
module tb_jump_ctl;
  import jump_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_space = 1'b0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic        landed = 1'b1;
  logic        launch_ready = 1'b0;
  logic        launch_valid;
  logic [11:0] launch_vy;
  logic [1:0]  launch_dir;
  logic        walk_left;
  logic        walk_right;
  logic        charging;
  logic [5:0]  charge_level;

  int n_cmp = 0;
  int n_bad = 0;

  jump_ctl #(
    .TICK_DIV   (4),
    .CHARGE_MAX (32),
    .VEL_STEP   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_space    (key_space),
    .key_left     (key_left),
    .key_right    (key_right),
    .landed       (landed),
    .launch_ready (launch_ready),
    .launch_valid (launch_valid),
    .launch_vy    (launch_vy),
    .launch_dir   (launch_dir),
    .walk_left    (walk_left),
    .walk_right   (walk_right),
    .charging     (charging),
    .charge_level (charge_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    landed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid act=%b exp=0", launch_valid); end
    n_cmp++; if (launch_vy !== 12'd0) begin n_bad++; $display("FAIL rst_vy act=%0d exp=0", launch_vy); end
    n_cmp++; if (charge_level !== 6'd0) begin n_bad++; $display("FAIL rst_charge act=%0d exp=0", charge_level); end
    n_cmp++; if ({walk_left, walk_right, charging} !== 3'b000) begin n_bad++; $display("FAIL rst_flags act=%b exp=000", {walk_left, walk_right, charging}); end
    rst = 1'b0;
  endtask

  task automatic test_walk();
    key_left = 1'b1; step();
    n_cmp++; if ({walk_left, walk_right} !== 2'b10) begin n_bad++; $display("FAIL walk_l act=%b exp=10", {walk_left, walk_right}); end
    key_right = 1'b1; step();
    n_cmp++; if ({walk_left, walk_right} !== 2'b00) begin n_bad++; $display("FAIL walk_both act=%b exp=00", {walk_left, walk_right}); end
    key_left = 1'b0; step();
    n_cmp++; if ({walk_left, walk_right} !== 2'b01) begin n_bad++; $display("FAIL walk_r act=%b exp=01", {walk_left, walk_right}); end
    key_right = 1'b0; step();
    n_cmp++; if ({walk_left, walk_right} !== 2'b00) begin n_bad++; $display("FAIL walk_none act=%b exp=00", {walk_left, walk_right}); end
  endtask

  task automatic test_charge_basic();
    int n;
    key_space = 1'b1; step();
    n_cmp++; if (charging !== 1'b1) begin n_bad++; $display("FAIL chg_on act=%b exp=1", charging); end
    n_cmp++; if (charge_level !== 6'd1) begin n_bad++; $display("FAIL chg_start act=%0d exp=1", charge_level); end
    n = 0;
    while (charge_level !== 6'd11 && n < 200) begin step(); n++; end
    n_cmp++; if (charge_level !== 6'd11) begin n_bad++; $display("FAIL chg_reach11 act=%0d exp=11", charge_level); end
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL pre_valid act=%b exp=0", launch_valid); end
    key_space = 1'b0; step();
    n_cmp++; if (launch_valid !== 1'b1) begin n_bad++; $display("FAIL rel_valid act=%b exp=1", launch_valid); end
    n_cmp++; if (launch_vy !== 12'd22) begin n_bad++; $display("FAIL rel_vy act=%0d exp=22", launch_vy); end
    n_cmp++; if (launch_dir !== 2'b00) begin n_bad++; $display("FAIL rel_dir act=%b exp=00", launch_dir); end
    n_cmp++; if (charging !== 1'b0) begin n_bad++; $display("FAIL rel_chg act=%b exp=0", charging); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if ({launch_valid, launch_vy, launch_dir} !== {1'b1, 12'd22, 2'b00}) begin
        n_bad++; $display("FAIL bp_hold%0d act=%b/%0d/%b exp=1/22/00", i, launch_valid, launch_vy, launch_dir);
      end
    end
    launch_ready = 1'b1; landed = 1'b0; step();
    launch_ready = 1'b0;
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop act=%b exp=0", launch_valid); end
    n_cmp++; if (charge_level !== 6'd0) begin n_bad++; $display("FAIL bp_clr act=%0d exp=0", charge_level); end
    n_cmp++; if (dut.state !== ST_AIR) begin n_bad++; $display("FAIL bp_air act=%0d exp=%0d", dut.state, ST_AIR); end
    key_left = 1'b1; key_space = 1'b1; step();
    n_cmp++; if ({walk_left, charging} !== 2'b00) begin n_bad++; $display("FAIL air_ignore act=%b exp=00", {walk_left, charging}); end
    key_left = 1'b0; key_space = 1'b0; landed = 1'b1; step();
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL land_idle act=%0d exp=%0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_saturate();
    int n;
    key_space = 1'b1; step();
    n = 0;
    while (charge_level !== 6'd32 && n < 300) begin step(); n++; end
    n_cmp++; if (charge_level !== 6'd32) begin n_bad++; $display("FAIL sat_reach act=%0d exp=32", charge_level); end
`ifdef JUMP_CTL_AUTO_RELEASE_EN
    key_right = 1'b1; step();
`else
    repeat (300) step();
    n_cmp++; if (charge_level !== 6'd32) begin n_bad++; $display("FAIL sat_hold act=%0d exp=32", charge_level); end
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL sat_novalid act=%b exp=0", launch_valid); end
    key_right = 1'b1; key_space = 1'b0; step();
`endif
    n_cmp++; if (launch_valid !== 1'b1) begin n_bad++; $display("FAIL sat_valid act=%b exp=1", launch_valid); end
    n_cmp++; if (launch_vy !== 12'd64) begin n_bad++; $display("FAIL sat_vy act=%0d exp=64", launch_vy); end
    n_cmp++; if (launch_dir !== 2'b10) begin n_bad++; $display("FAIL sat_dir act=%b exp=10", launch_dir); end
    launch_ready = 1'b1; landed = 1'b0; step();
    launch_ready = 1'b0; key_right = 1'b0;
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL sat_acc act=%b exp=0", launch_valid); end
  endtask

  task automatic test_hold();
    key_space = 1'b1; step();
    landed = 1'b1; step();
    n_cmp++; if (dut.state !== ST_HOLD) begin n_bad++; $display("FAIL hold_st act=%0d exp=%0d", dut.state, ST_HOLD); end
    repeat (8) step();
    n_cmp++; if ({charging, charge_level} !== 7'd0) begin n_bad++; $display("FAIL hold_nochg act=%b/%0d exp=0/0", charging, charge_level); end
    key_space = 1'b0; step();
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL hold_idle act=%0d exp=%0d", dut.state, ST_IDLE); end
    key_space = 1'b1; step();
    n_cmp++; if ({charging, charge_level} !== {1'b1, 6'd1}) begin n_bad++; $display("FAIL hold_new act=%b/%0d exp=1/1", charging, charge_level); end
  endtask

  task automatic test_ledge();
    landed = 1'b0; step();
    n_cmp++; if (dut.state !== ST_AIR) begin n_bad++; $display("FAIL ledge_air act=%0d exp=%0d", dut.state, ST_AIR); end
    n_cmp++; if ({charging, charge_level} !== 7'd0) begin n_bad++; $display("FAIL ledge_clr act=%b/%0d exp=0/0", charging, charge_level); end
    key_space = 1'b0; repeat (3) step();
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL ledge_nolaunch act=%b exp=0", launch_valid); end
    landed = 1'b1; step();
  endtask

  task automatic test_tick_release();
    int n;
    key_space = 1'b1; step();
    n = 0;
    while (charge_level !== 6'd2 && n < 20) begin step(); n++; end
    n_cmp++; if (charge_level !== 6'd2) begin n_bad++; $display("FAIL tr_reach2 act=%0d exp=2", charge_level); end
    repeat (3) step();
    n_cmp++; if (charge_level !== 6'd2) begin n_bad++; $display("FAIL tr_steady act=%0d exp=2", charge_level); end
    key_space = 1'b0; step();
    n_cmp++; if (launch_vy !== 12'd6) begin n_bad++; $display("FAIL tr_vy act=%0d exp=6", launch_vy); end
    n_cmp++; if (charge_level !== 6'd3) begin n_bad++; $display("FAIL tr_lvl act=%0d exp=3", charge_level); end
    launch_ready = 1'b1; landed = 1'b0; step();
    launch_ready = 1'b0; landed = 1'b1; step();
  endtask

  task automatic test_reset_launch();
    key_space = 1'b1; step();
    key_space = 1'b0; key_left = 1'b1; step();
    n_cmp++; if ({launch_valid, launch_dir} !== 3'b101) begin n_bad++; $display("FAIL rl_pre act=%b exp=101", {launch_valid, launch_dir}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({launch_valid, launch_dir, charging} !== 4'b0000) begin n_bad++; $display("FAIL rl_async act=%b exp=0000", {launch_valid, launch_dir, charging}); end
    n_cmp++; if ({launch_vy, charge_level} !== 18'd0) begin n_bad++; $display("FAIL rl_data act=%0d/%0d exp=0/0", launch_vy, charge_level); end
    @(negedge clk);
    rst = 1'b0; key_left = 1'b0; step();
    n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL rl_idle act=%0d exp=%0d", dut.state, ST_IDLE); end
    n_cmp++; if (launch_valid !== 1'b0) begin n_bad++; $display("FAIL rl_novalid act=%b exp=0", launch_valid); end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_charge_basic();
    test_backpressure();
    test_saturate();
    test_hold();
    test_ledge();
    test_tick_release();
    test_reset_launch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
